// File: rtl/nios2_debug_pkg.sv
// Shared constants and command type for the Nios II debug slave, system-clock side.
// Optional feature macro: NIOS2_DBG_UIR_FLUSH_EN (update-IR flushes the command queue).
package nios2_debug_pkg;

    localparam int IR_W_DEF = 2;
    localparam int SR_W_DEF = 38;

    localparam logic [IR_W_DEF-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [IR_W_DEF-1:0] IR_TRACECTRL = 2'd1;
    localparam logic [IR_W_DEF-1:0] IR_BREAK     = 2'd2;
    localparam logic [IR_W_DEF-1:0] IR_TRACEMEM  = 2'd3;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] sr;
    } cmd_t;

endpackage

// File: rtl/nios2_debug_cmd_fifo.sv
// Command queue: DEPTH entries, synchronous push/pop, flush empties it.
// Flush is only driven when NIOS2_DBG_UIR_FLUSH_EN is defined in the top.
module nios2_debug_cmd_fifo
    import nios2_debug_pkg::*;
#(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Full and empty share the index bits; the extra MSB tells them apart
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_comb begin
        rptr_d = rptr_q + (AW+1)'(do_pop);
        wptr_d = wptr_q + (AW+1)'(do_push);
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/nios2_debug_slave_sysclk_q.sv
// System-clock command decoder: syncs UDR/UIR, queues {ir,sr}, emits one-hot strobes.
// Define NIOS2_DBG_UIR_FLUSH_EN to let an update-IR edge flush the queue.
module nios2_debug_slave_sysclk_q
    import nios2_debug_pkg::*;
#(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int ACTION_BIT  = 34,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [SR_W-1:0]      sr,
    input  logic                 cmd_ready,
    input  logic                 ovf_clr,
    output logic [SR_W-1:0]      jdo,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 cmd_pending,
    output logic                 ovf
);

    localparam int CW = IR_W + SR_W;
    localparam int NS = 2**IR_W;

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic                   udr_hist_q;
    logic                   push;
    logic                   flush;
    logic                   pop;
    logic                   empty;
    logic                   full;
    logic [CW-1:0]          head;
    logic [IR_W-1:0]        head_ir;

    logic [SR_W-1:0]        jdo_q, jdo_d;
    logic [NS-1:0]          ta_q, ta_d;
    logic [NS-1:0]          tna_q, tna_d;
    logic                   ovf_q, ovf_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_q <= '0;
            udr_hist_q <= 1'b0;
        end else begin
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
        end
    end

    assign push = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;

`ifdef NIOS2_DBG_UIR_FLUSH_EN
    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic                   uir_hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            uir_hist_q <= 1'b0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
        end
    end

    assign flush = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;
`else
    logic unused_uir;
    assign unused_uir = vs_uir;
    assign flush      = 1'b0;
`endif

    assign cmd_pending = ~empty;
    assign pop         = ~empty & cmd_ready;
    assign head_ir     = head[SR_W +: IR_W];

    nios2_debug_cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i ({ir_in, sr}),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (head),
        .empty_o (empty),
        .full_o  (full)
    );

    always_comb begin
        jdo_d = jdo_q;
        ta_d  = '0;
        tna_d = '0;
        ovf_d = ovf_q;
        if (pop) begin
            jdo_d          = head[SR_W-1:0];
            ta_d[head_ir]  = head[ACTION_BIT];
            tna_d[head_ir] = ~head[ACTION_BIT];
        end
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        // A flushed push is discarded on purpose and is not an overflow
        if (push && full && !pop && !flush) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo_q <= '0;
            ta_q  <= '0;
            tna_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            jdo_q <= jdo_d;
            ta_q  <= ta_d;
            tna_q <= tna_d;
            ovf_q <= ovf_d;
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_nios2_debug_slave_sysclk_q.sv
// Bench for nios2_debug_slave_sysclk_q: queue-level model plus directed scenarios.
// Honours NIOS2_DBG_UIR_FLUSH_EN for the flush scenario.
module tb_nios2_debug_slave_sysclk_q;

    localparam int S     = 2;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        vs_udr;
    logic        vs_uir;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_ready;
    logic        ovf_clr;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        cmd_pending;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    nios2_debug_slave_sysclk_q dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .cmd_pending    (cmd_pending),
        .ovf            (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Model: a push happens S edges after a sampled rising edge of the strobe
    bit          us[$];
    bit          ui[$];
    logic [39:0] mq[$];
    logic [37:0] m_jdo;
    logic [3:0]  m_ta;
    logic [3:0]  m_tna;
    logic        m_ovf;

    function automatic bit rise_at(input bit s[$], input int m);
        bit cur, prev;
        cur  = (m - S >= 0) ? s[m-S] : 1'b0;
        prev = (m - S - 1 >= 0) ? s[m-S-1] : 1'b0;
        return cur && !prev;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int          m;
        bit          pu;
        bit          fl;
        logic [39:0] h;
        if (!reset_n) begin
            us.delete();
            ui.delete();
            mq.delete();
            m_jdo = '0;
            m_ta  = '0;
            m_tna = '0;
            m_ovf = 1'b0;
        end else begin
            us.push_back(vs_udr);
            ui.push_back(vs_uir);
            m  = us.size() - 1;
            pu = rise_at(us, m);
`ifdef NIOS2_DBG_UIR_FLUSH_EN
            fl = rise_at(ui, m);
`else
            fl = 1'b0;
`endif
            m_ta  = '0;
            m_tna = '0;
            if (mq.size() > 0 && cmd_ready) begin
                h     = mq.pop_front();
                m_jdo = h[37:0];
                if (h[34]) m_ta[h[39:38]] = 1'b1;
                else       m_tna[h[39:38]] = 1'b1;
            end
            if (fl) mq.delete();
            if (ovf_clr) m_ovf = 1'b0;
            if (pu && !fl) begin
                if (mq.size() == DEPTH) m_ovf = 1'b1;
                else mq.push_back({ir_in, sr});
            end
        end
    end

    logic [37:0] obs[$];

    always @(negedge clk) begin
        chk("jdo", 64'(jdo), 64'(m_jdo));
        chk("take_action", 64'(take_action), 64'(m_ta));
        chk("take_no_action", 64'(take_no_action), 64'(m_tna));
        chk("cmd_pending", 64'(cmd_pending), 64'(mq.size() != 0));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("onehot", 64'($countones(take_action | take_no_action) <= 1),
            64'd1);
        if (|(take_action | take_no_action)) obs.push_back(jdo);
    end

    task automatic pulse(input logic [1:0] i, input logic [37:0] v);
        @(negedge clk);
        ir_in  = i;
        sr     = v;
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic single(input logic [1:0] i, input logic [37:0] v,
                          input logic [3:0] eta, input logic [3:0] etna);
        @(negedge clk);
        ir_in     = i;
        sr        = v;
        cmd_ready = 1'b1;
        vs_udr    = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
        chk("c5_ta", 64'(take_action), 64'(eta));
        chk("c5_tna", 64'(take_no_action), 64'(etna));
        chk("c5_jdo", 64'(jdo), 64'(v));
        chk("c5_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        chk("c6_strobes", 64'(take_action | take_no_action), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    logic [37:0] vals[5];

    initial begin
        reset_n   = 1'b0;
        vs_udr    = 1'b0;
        vs_uir    = 1'b0;
        ir_in     = '0;
        sr        = '0;
        cmd_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_pending", 64'(cmd_pending), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        single(2'd2, 38'h07_0000_1234, 4'b0100, 4'b0000);
        single(2'd0, 38'h00_1234_5678, 4'b0000, 4'b0001);
        single(2'd3, 38'h3f_ffff_ffff, 4'b1000, 4'b0000);
        single(2'd1, 38'h0b_dead_beef, 4'b0000, 4'b0010);

        // backpressure and overflow
        for (int k = 0; k < 5; k++)
            vals[k] = 38'h04_0000_0010 + 38'(k * 38'h8_0000_0001);
        cmd_ready = 1'b0;
        obs.delete();
        for (int k = 0; k < 5; k++) pulse(2'(k), vals[k]);
        chk("bp_pending", 64'(cmd_pending), 64'd1);
        chk("bp_ovf", 64'(ovf), 64'd1);
        cmd_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("bp_count", 64'(obs.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            if (k < obs.size()) chk("bp_order", 64'(obs[k]), 64'(vals[k]));
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", 64'(ovf), 64'd0);

        // full with a pop on the push edge
        cmd_ready = 1'b0;
        obs.delete();
        for (int k = 0; k < 4; k++) pulse(2'(k), vals[k] ^ 38'h1);
        chk("full_pending", 64'(cmd_pending), 64'd1);
        @(negedge clk);
        ir_in  = 2'd2;
        sr     = 38'h05_5555_5555;
        vs_udr = 1'b1;
        repeat (2) @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (8) @(negedge clk);
        chk("full_ovf", 64'(ovf), 64'd0);
        chk("full_count", 64'(obs.size()), 64'd5);
        if (obs.size() == 5) chk("full_last", 64'(obs[4]), 64'h05_5555_5555);

        // reset mid-drain
        cmd_ready = 1'b0;
        obs.delete();
        for (int k = 0; k < 3; k++) pulse(2'(k), vals[k]);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_pending", 64'(cmd_pending), 64'd0);
        chk("arst_jdo", 64'(jdo), 64'd0);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_nostrobe", 64'(obs.size()), 64'd0);

        // update-IR flush
        cmd_ready = 1'b0;
        for (int k = 0; k < 3; k++) pulse(2'(k), vals[k] ^ 38'h2);
        @(negedge clk);
        vs_uir = 1'b1;
        repeat (3) @(negedge clk);
        vs_uir = 1'b0;
        repeat (3) @(negedge clk);
`ifdef NIOS2_DBG_UIR_FLUSH_EN
        chk("flush_pending", 64'(cmd_pending), 64'd0);
`else
        chk("flush_pending", 64'(cmd_pending), 64'd1);
`endif
        cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
`ifdef NIOS2_DBG_UIR_FLUSH_EN
        chk("flush_count", 64'(obs.size()), 64'd0);
`else
        chk("flush_count", 64'(obs.size()), 64'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
